program_loader: RTL and testbench

Boot-time writer for the byte-wide program memory that the instruction fetcher reads. It accepts a framed byte stream over a valid/ready handshake and writes the payload into memory starting at a base address carried in the frame. It checks an 8-bit checksum and holds the processor in reset until a good frame has been committed. It sits beside the memory: the fetcher reads through `m_addr`/`m_read`, and this block drives the write side.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 21 ++
 rtl/commons.sv | 12 +
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
`include "commons.sv"
`default_nettype none
// +----------------------------------------------------------------------------+
// | loader_pkg                                                                 |
// | Shared types and constants for the boot-time program loader.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package loader_pkg;
  localparam int         LOADER_W          = `W;
  localparam int         LOADER_BASE_BYTES = 4;
  localparam int         LOADER_LEN_BYTES  = 2;
  localparam logic [7:0] LOADER_MAGIC      = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BASE = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;
endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`include "commons.sv"
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader_if                                                          |
// | Byte stream (valid/ready) in, program-memory write port out.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface program_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic `WORD  m_addr;
  logic [7:0]  m_wdata;
  logic        m_we;

  // Host side: produces the boot stream and observes memory writes
  modport master (output s_data, s_valid, input s_ready, m_addr, m_wdata, m_we);
  // Loader side
  modport slave  (input s_data, s_valid, output s_ready, m_addr, m_wdata, m_we);
endinterface
`default_nettype wire

// File: rtl/commons.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | commons                                                                    |
// | Shared width macros for the processor memory system.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef COMMONS_SV
`define COMMONS_SV
`define W 32
`define WORD [`W-1:0]
`endif
`default_nettype wire

// File: rtl/program_loader.sv
`include "commons.sv"
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader                                                             |
// | Parses a framed boot stream, writes the payload into program memory,     |
// | verifies an 8-bit checksum and releases the CPU reset on success.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] MAGIC = LOADER_MAGIC
) (
  input  logic               clk,
  input  logic               rst,
  program_loader_if.slave    bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam int BASE_BITS = 8 * LOADER_BASE_BYTES;
  localparam int LEN_BITS  = 8 * LOADER_LEN_BYTES;

  loader_state_t           state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [BASE_BITS-1:0]    base_q, base_d;
  logic [LEN_BITS-1:0]     len_q, len_d;
  logic [LEN_BITS-1:0]     idx_q, idx_d;
  logic [7:0]              sum_q, sum_d;
  logic                    we_q, we_d;
  logic [LOADER_W-1:0]     addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    s_ready;
  logic                    xfer;
  logic [LEN_BITS-1:0]     len_next;

  // Ready in every parsing state; forced low while reset is asserted
  assign s_ready  = !rst && (state_q inside {IDLE, BASE, LEN, DATA, CSUM});
  assign xfer     = bus.s_valid && s_ready;
  // Length bytes arrive little-endian, so each new byte enters at the top
  assign len_next = {bus.s_data, len_q[LEN_BITS-1:8]};

  // Next-state and datapath updates for the frame parser
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && bus.s_data == MAGIC) begin
          state_d = BASE;
          cnt_d   = 2'd0;
        end
      end
      BASE: begin
        if (xfer) begin
          base_d = {bus.s_data, base_q[BASE_BITS-1:8]};
          if (cnt_q == 2'(LOADER_BASE_BYTES - 1)) begin
            state_d = LEN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      LEN: begin
        if (xfer) begin
          len_d = len_next;
          idx_d = '0;
          sum_d = 8'd0;
          if (cnt_q == 2'(LOADER_LEN_BYTES - 1)) begin
            cnt_d   = 2'd0;
            state_d = (len_next != '0) ? DATA : CSUM;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = base_q[LOADER_W-1:0] + LOADER_W'(idx_q);
          wdata_d = bus.s_data;
          sum_d   = sum_q + bus.s_data;
          idx_d   = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          if (bus.s_data == sum_q) begin
            state_d   = DONE;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also cancels any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_we    = we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign cpu_rst     = cpu_rst_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_program_loader                                                          |
// | Directed self-checking bench for the boot-time program loader.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_program_loader;
  import loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
    logic        cpu_rst;
  } wr_t;

  logic clk;
  logic rst;
  logic cpu_rst;
  logic done;
  logic err;

  int   checks;
  int   errors;
  int   cyc;
  int   gap_viol;
  logic hs_prev;
  wr_t  wq[$];

  program_loader_if bus();

  program_loader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record every memory write and flag any strobe not preceded by a handshake
  always @(negedge clk) begin
    if (bus.m_we === 1'b1) begin
      wq.push_back('{addr: bus.m_addr, data: bus.m_wdata, cyc: cyc, cpu_rst: cpu_rst});
      if (!hs_prev) gap_viol = gap_viol + 1;
    end
    hs_prev = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input byte_q_t bytes);
    foreach (bytes[i]) send(bytes[i]);
    bus.s_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b expected 0", bus.m_we); end
    checks++; if (bus.m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h expected 0", bus.m_addr); end
    checks++; if (bus.m_wdata !== 8'h0) begin errors++; $display("FAIL reset_m_wdata: got %h expected 0", bus.m_wdata); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready: got %b expected 1", bus.s_ready); end
    wq.delete();
  endtask

  task automatic test_good_frame();
    logic [31:0] ea[3];
    logic [7:0]  ed[3];
    ea = '{32'h100, 32'h101, 32'h102};
    ed = '{8'h11, 8'h22, 8'h33};
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66});
    checks++; if (wq.size() !== 3) begin errors++; $display("FAIL good_wr_count: got %0d expected 3", wq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
          errors++;
          $display("FAIL good_wr%0d: got (%h,%h) expected (%h,%h)", i, wq[i].addr, wq[i].data, ea[i], ed[i]);
        end
      end
      checks++; if (wq[2].cyc - wq[0].cyc !== 2) begin errors++; $display("FAIL good_wr_b2b: got span %0d expected 2", wq[2].cyc - wq[0].cyc); end
      checks++; if (wq[2].cpu_rst !== 1'b1) begin errors++; $display("FAIL good_wr_before_release: got cpu_rst %b expected 1", wq[2].cpu_rst); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b expected 1", done); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL good_cpu_rst: got %b expected 0", cpu_rst); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err: got %b expected 0", err); end
    bus.s_valid = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL good_s_ready_after: got %b expected 0", bus.s_ready); end
    idle_cycle();
    checks++; if (done !== 1'b1 || bus.m_we !== 1'b0) begin errors++; $display("FAIL good_terminal: got done %b m_we %b expected 1 0", done, bus.m_we); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67});
    checks++; if (wq.size() !== 3) begin errors++; $display("FAIL bad_wr_count: got %0d expected 3", wq.size()); end
    else begin
      checks++; if (wq[2].addr !== 32'h102 || wq[2].data !== 8'h33) begin errors++; $display("FAIL bad_wr_last: got (%h,%h) expected (00000102,33)", wq[2].addr, wq[2].data); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", err); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL bad_cpu_rst: got %b expected 1", cpu_rst); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bad_done: got %b expected 0", done); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bad_s_ready: got %b expected 0", bus.s_ready); end
  endtask

  task automatic test_junk_empty();
    do_reset();
    send_bytes('{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b expected 1", done); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL empty_cpu_rst: got %b expected 0", cpu_rst); end
    idle_cycle();
    idle_cycle();
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL empty_no_writes: got %0d writes expected 0", wq.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea[3];
    logic [7:0]  ed[3];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    ed = '{8'h10, 8'h20, 8'h30};
    do_reset();
    send_bytes('{8'hA5, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h10, 8'h20, 8'h30, 8'h60});
    checks++; if (wq.size() !== 3) begin errors++; $display("FAIL wrap_wr_count: got %0d expected 3", wq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq[i].addr !== ea[i] || wq[i].data !== ed[i]) begin
          errors++;
          $display("FAIL wrap_wr%0d: got (%h,%h) expected (%h,%h)", i, wq[i].addr, wq[i].data, ea[i], ed[i]);
        end
      end
    end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wrap_done: got done %b err %b expected 1 0", done, err); end
  endtask

  task automatic test_gaps_reset();
    do_reset();
    gap_viol = 0;
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h04, 8'h00});
    send(8'hAA);
    idle_cycle();
    idle_cycle();
    send(8'hBB);
    // Reset lands while the BB write is on the bus; a byte is offered meanwhile
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hCC;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL gap_rst_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.m_we !== 1'b1) begin errors++; $display("FAIL gap_bb_strobe: got %b expected 1", bus.m_we); end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL gap_after_rst_m_we: got %b expected 0", bus.m_we); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL gap_after_rst_cpu_rst: got %b expected 1", cpu_rst); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL gap_after_rst_state: got %0d expected %0d", dut.state_q, IDLE); end
    idle_cycle();
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL gap_wr_count: got %0d expected 2", wq.size()); end
    else begin
      checks++; if (wq[0].addr !== 32'h200 || wq[0].data !== 8'hAA) begin errors++; $display("FAIL gap_wr0: got (%h,%h) expected (00000200,aa)", wq[0].addr, wq[0].data); end
      checks++; if (wq[1].addr !== 32'h201 || wq[1].data !== 8'hBB) begin errors++; $display("FAIL gap_wr1: got (%h,%h) expected (00000201,bb)", wq[1].addr, wq[1].data); end
    end
    checks++; if (gap_viol !== 0) begin errors++; $display("FAIL gap_strobe_without_handshake: got %0d expected 0", gap_viol); end
    wq.delete();
    send_bytes('{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h5A, 8'h5A});
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL fresh_done: got done %b cpu_rst %b expected 1 0", done, cpu_rst); end
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL fresh_wr_count: got %0d expected 1", wq.size()); end
    else begin
      checks++; if (wq[0].addr !== 32'h300 || wq[0].data !== 8'h5A) begin errors++; $display("FAIL fresh_wr0: got (%h,%h) expected (00000300,5a)", wq[0].addr, wq[0].data); end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    gap_viol    = 0;
    hs_prev     = 1'b0;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_junk_empty();
    test_wrap();
    test_gaps_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
